// File: rtl/if_fetch_axi_pkg.sv
// Shared definitions for the instruction-fetch AXI master: FSM encoding,
// exception codes and the AXI4 constants used by single-beat fetches.
package if_fetch_axi_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_ADEL_IF = 32'h0000_0010;
    localparam logic [31:0] EXC_IBE     = 32'h0000_0020;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Either error response turns the fetched word into a bus-error exception.
    function automatic logic is_resp_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/if_fetch_axi_if.sv
// AXI4 read-address and read-data channels used by the fetch unit.
interface if_fetch_axi_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/if_fetch_axi_inst_buf.sv
// Holding register for the instruction handed to ID: word, its PC, its
// exception code and the valid flag.
module if_fetch_axi_inst_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_exc,
    input  logic        i_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_exc,
    output logic        o_valid
);
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_exc;
    logic        r_valid;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst  <= '0;
            r_pc    <= '0;
            r_exc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_load) begin
                r_inst <= i_inst;
                r_pc   <= i_pc;
                r_exc  <= i_exc;
            end
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_exc   = r_exc;
    assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch_axi.sv
// Instruction-fetch bus master: one single-beat AXI4 read per PC, result held
// for ID, with flush handling that drains any read already on the bus.
module if_fetch_axi
    import if_fetch_axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           fetch_exc_i,
    input  logic                  flush_i,
    input  logic                  id_stall_i,
    output logic                  stall_req_o,
    output logic [31:0]           inst_o,
    output logic [31:0]           inst_pc_o,
    output logic [31:0]           inst_exc_o,
    output logic                  inst_valid_o,
    if_fetch_axi_if.master        axi
);
    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_kill;
    logic        w_kill_next;
    logic [31:0] r_araddr;
    logic        w_addr_load;
    logic        w_r_beat;
    logic        w_buf_load;
    logic [31:0] w_buf_inst;
    logic [31:0] w_buf_pc;
    logic [31:0] w_buf_exc;
    logic        w_unused_rid;

    // rready is high in every state that reacts to an R beat, so valid&last is the handshake.
    assign w_r_beat     = axi.rvalid & axi.rlast;
    assign w_unused_rid = ^axi.rid;

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_kill_next  = r_kill;
        w_addr_load  = 1'b0;
        w_buf_load   = 1'b0;
        w_buf_inst   = '0;
        w_buf_pc     = pc_i;
        w_buf_exc    = fetch_exc_i;
        case (r_state)
            S_IDLE: begin
                if (!flush_i) begin
                    w_buf_load = 1'b1;
                    if (fetch_exc_i != EXC_NONE) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_addr_load  = 1'b1;
                        w_state_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (axi.arready) begin
                    w_state_next = (flush_i || r_kill) ? S_DISCARD : S_DATA;
                    w_kill_next  = 1'b0;
                end else if (flush_i) begin
                    w_kill_next = 1'b1;
                end
            end
            S_DATA: begin
                if (flush_i) begin
                    w_state_next = w_r_beat ? S_IDLE : S_DISCARD;
                end else if (w_r_beat) begin
                    w_buf_load   = 1'b1;
                    w_buf_inst   = axi.rdata;
                    w_buf_pc     = r_araddr;
                    w_buf_exc    = is_resp_err(axi.rresp) ? EXC_IBE : EXC_NONE;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush_i || !id_stall_i) w_state_next = S_IDLE;
            end
            S_DISCARD: begin
                if (w_r_beat) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_kill   <= 1'b0;
            r_araddr <= '0;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
            if (w_addr_load) r_araddr <= pc_i;
        end
    end

    if_fetch_axi_inst_buf u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_inst  (w_buf_inst),
        .i_pc    (w_buf_pc),
        .i_exc   (w_buf_exc),
        .i_valid (w_state_next == S_HOLD),
        .o_inst  (inst_o),
        .o_pc    (inst_pc_o),
        .o_exc   (inst_exc_o),
        .o_valid (inst_valid_o)
    );

    // AR/R controls decode the registered state only; no AXI input reaches them combinationally.
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (r_state == S_ADDR);
    assign axi.rready  = (r_state == S_DATA) || (r_state == S_DISCARD);

    assign stall_req_o = !((r_state == S_HOLD) && !id_stall_i);
endmodule

// File: tb/tb_if_fetch_axi.sv
// Directed bench for if_fetch_axi: table of zero-wait fetches plus hand-written
// sequences for AR back-pressure with flush, ID stall, flushes and async reset.
module tb_if_fetch_axi;
    import if_fetch_axi_pkg::*;

    localparam int ID_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] fetch_exc_i = '0;
    logic        flush_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        stall_req_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_exc_o;
    logic        inst_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_axi_if #(.ID_W(ID_W)) axi ();

    if_fetch_axi #(.ID_W(ID_W), .AXI_ID(4'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .fetch_exc_i  (fetch_exc_i),
        .flush_i      (flush_i),
        .id_stall_i   (id_stall_i),
        .stall_req_o  (stall_req_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_exc_o   (inst_exc_o),
        .inst_valid_o (inst_valid_o),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_inst;
        logic [31:0] exp_exc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rid     = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_arvalid"}, axi.arvalid, 0);
        check({tag, "_rready"}, axi.rready, 0);
        check({tag, "_valid"}, inst_valid_o, 0);
        check({tag, "_inst"}, inst_o, 0);
        check({tag, "_inst_pc"}, inst_pc_o, 0);
        check({tag, "_inst_exc"}, inst_exc_o, 0);
        check({tag, "_araddr"}, axi.araddr, 0);
        check({tag, "_stall"}, stall_req_o, 1);
    endtask

    // Entered with the DUT in IDLE; leaves it in DATA, one cycle after the AR handshake.
    task automatic go_to_data(input logic [31:0] pc);
        pc_i = pc;
        fetch_exc_i = EXC_NONE;
        bus_idle();
        tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
    endtask

    task automatic go_to_hold(input logic [31:0] pc, input logic [31:0] data);
        go_to_data(pc);
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = data;
        tick();
        bus_idle();
    endtask

    initial begin
        vecs[0] = '{32'hBFC0_0000, EXC_NONE,    32'h3C08_0001, 2'b00, 32'h3C08_0001, EXC_NONE};
        vecs[1] = '{32'hBFC0_0004, EXC_NONE,    32'h8C09_0004, 2'b10, 32'h8C09_0004, EXC_IBE};
        vecs[2] = '{32'hBFC0_0008, EXC_NONE,    32'h2442_0001, 2'b00, 32'h2442_0001, EXC_NONE};
        vecs[3] = '{32'hBFC0_0002, EXC_ADEL_IF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, EXC_ADEL_IF};
        vecs[4] = '{32'h8000_0010, EXC_NONE,    32'hA5A5_5A5A, 2'b11, 32'hA5A5_5A5A, EXC_IBE};
        vecs[5] = '{32'h1234_5678, EXC_NONE,    32'h0BAD_F00D, 2'b01, 32'h0BAD_F00D, EXC_NONE};

        bus_idle();
        #1;
        check_reset_vals("rst");
        repeat (3) tick();
        rst_n = 1'b1;

        // Zero-wait fetches: IDLE, ADDR, DATA, then HOLD on the fourth cycle.
        for (int i = 0; i < 6; i++) begin
            pc_i = vecs[i].pc;
            fetch_exc_i = vecs[i].exc;
            id_stall_i = 1'b0;
            bus_idle();
            #1;
            check($sformatf("v%0d_idle_valid", i), inst_valid_o, 0);
            check($sformatf("v%0d_idle_stall", i), stall_req_o, 1);
            check($sformatf("v%0d_idle_arvalid", i), axi.arvalid, 0);
            tick();
            if (vecs[i].exc == EXC_NONE) begin
                pc_i = 32'hDEAD_BEEF;
                axi.arready = 1'b1;
                #1;
                check($sformatf("v%0d_arvalid", i), axi.arvalid, 1);
                check($sformatf("v%0d_araddr", i), axi.araddr, vecs[i].pc);
                check($sformatf("v%0d_ar_const", i),
                      {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
                check($sformatf("v%0d_addr_stall", i), stall_req_o, 1);
                tick();
                axi.arready = 1'b0;
                axi.rvalid  = 1'b1;
                axi.rlast   = 1'b1;
                axi.rdata   = vecs[i].rdata;
                axi.rresp   = vecs[i].rresp;
                #1;
                check($sformatf("v%0d_rready", i), axi.rready, 1);
                check($sformatf("v%0d_data_arvalid", i), axi.arvalid, 0);
                check($sformatf("v%0d_data_valid", i), inst_valid_o, 0);
                tick();
                bus_idle();
            end
            #1;
            check($sformatf("v%0d_hold_valid", i), inst_valid_o, 1);
            check($sformatf("v%0d_inst", i), inst_o, vecs[i].exp_inst);
            check($sformatf("v%0d_inst_pc", i), inst_pc_o, vecs[i].pc);
            check($sformatf("v%0d_inst_exc", i), inst_exc_o, vecs[i].exp_exc);
            check($sformatf("v%0d_hold_stall", i), stall_req_o, 0);
            check($sformatf("v%0d_hold_arvalid", i), axi.arvalid, 0);
            tick();
        end

        // AR held off five cycles with a flush in the second: arvalid must stay up and the beat be drained.
        pc_i = 32'hBFC0_0200;
        fetch_exc_i = EXC_NONE;
        bus_idle();
        tick();
        for (int w = 1; w <= 5; w++) begin
            flush_i = (w == 2);
            #1;
            check($sformatf("t2_arvalid_w%0d", w), axi.arvalid, 1);
            check($sformatf("t2_araddr_w%0d", w), axi.araddr, 32'hBFC0_0200);
            tick();
        end
        flush_i = 1'b0;
        axi.arready = 1'b1;
        #1;
        check("t2_arvalid_hs", axi.arvalid, 1);
        tick();
        axi.arready = 1'b0;
        #1;
        check("t2_discard_rready", axi.rready, 1);
        check("t2_discard_arvalid", axi.arvalid, 0);
        check("t2_discard_valid", inst_valid_o, 0);
        tick();
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = 32'hBAD0_BAD0;
        #1;
        check("t2_beat_rready", axi.rready, 1);
        tick();
        bus_idle();
        flush_i = 1'b1;
        #1;
        check("t2_idle_rready", axi.rready, 0);
        check("t2_idle_valid", inst_valid_o, 0);
        check("t2_idle_stall", stall_req_o, 1);
        tick();
        flush_i = 1'b0;
        #1;
        check("t2_flush_idle_arvalid", axi.arvalid, 0);

        // ID stall in HOLD for three cycles, then release.
        id_stall_i = 1'b1;
        go_to_hold(32'hBFC0_0100, 32'h1111_2222);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t5_valid_%0d", k), inst_valid_o, 1);
            check($sformatf("t5_inst_%0d", k), inst_o, 32'h1111_2222);
            check($sformatf("t5_pc_%0d", k), inst_pc_o, 32'hBFC0_0100);
            check($sformatf("t5_stall_%0d", k), stall_req_o, 1);
            tick();
        end
        id_stall_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("t5_release_stall", stall_req_o, 0);
        tick();
        #1;
        check("t5_after_valid", inst_valid_o, 0);
        check("t5_after_stall", stall_req_o, 1);
        tick();
        flush_i = 1'b0;

        // Flush while holding an instruction drops it.
        id_stall_i = 1'b1;
        go_to_hold(32'hBFC0_0500, 32'h7777_8888);
        #1;
        check("th_valid", inst_valid_o, 1);
        flush_i = 1'b1;
        tick();
        #1;
        check("th_flushed_valid", inst_valid_o, 0);
        check("th_flushed_stall", stall_req_o, 1);
        tick();
        flush_i = 1'b0;
        id_stall_i = 1'b0;

        // Flush in DATA before the beat arrives: DISCARD consumes the late beat.
        go_to_data(32'hBFC0_0600);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        check("td_discard_rready", axi.rready, 1);
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = 32'h9999_0000;
        tick();
        bus_idle();
        flush_i = 1'b1;
        #1;
        check("td_idle_rready", axi.rready, 0);
        check("td_idle_valid", inst_valid_o, 0);
        tick();
        flush_i = 1'b0;

        // Flush coinciding with the R handshake goes straight back to IDLE.
        go_to_data(32'hBFC0_0300);
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = 32'h5555_5555;
        flush_i = 1'b1;
        #1;
        check("t6_rready", axi.rready, 1);
        tick();
        bus_idle();
        flush_i = 1'b0;
        pc_i = 32'hBFC0_0400;
        #1;
        check("t6_idle_valid", inst_valid_o, 0);
        check("t6_idle_rready", axi.rready, 0);
        check("t6_idle_arvalid", axi.arvalid, 0);
        tick();
        #1;
        check("t6_next_arvalid", axi.arvalid, 1);
        check("t6_next_araddr", axi.araddr, 32'hBFC0_0400);

        // Asynchronous reset while in DATA.
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        #1;
        check("t6_data_rready", axi.rready, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        tick();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
